// File: rtl/div_pkg.sv
// Shared encodings, state names and small decode helpers for the RV32M divide sequencer.
package div_pkg;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      DIV_ST_IDLE  = 3'd0,
      DIV_ST_START = 3'd1,
      DIV_ST_WAIT  = 3'd2,
      DIV_ST_RESP  = 3'd3,
      DIV_ST_DRAIN = 3'd4
   } div_state_e;

   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

   function automatic logic div_op_signed(input div_op_e op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   function automatic logic div_op_rem(input div_op_e op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's complement: used both to take operand magnitudes and to restore result signs.
module div_sign_fix
   import div_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);

   // negate on request, pass through otherwise
   always_comb begin
      if (neg) begin
         res = ~val + {{(W-1){1'b0}}, 1'b1};
      end else begin
         res = val;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between execute and the iterative unsigned divider core (DIV/DIVU/REM/REMU).
// Optional last-result cache is enabled by defining DIV_CTRL_RESULT_CACHE_EN.
module div_ctrl
   import div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_vld_i,
   output logic            req_rdy_o,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            rsp_vld_o,
   input  logic            rsp_rdy_i,
   output logic [XLEN-1:0] rsp_data_o,
   output logic [XLEN-1:0] div_div1_o,
   output logic [XLEN-1:0] div_div2_o,
   output logic            div_vld_o,
   input  logic [XLEN-1:0] div_q_i,
   input  logic [XLEN-1:0] div_r_i,
   input  logic            div_rdy_i
);

   div_state_e      state;
   div_state_e      state_nxt;
   div_op_e         op;
   div_op_e         op_in;
   logic            q_neg;
   logic            r_neg;
   logic            accept;
   logic            in_signed;
   logic            rs1_neg;
   logic            rs2_neg;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;
   logic [XLEN-1:0] rsp_nxt;
   logic            cache_hit;
   logic [XLEN-1:0] hit_data;

   assign op_in     = div_op_e'(op_i);
   assign in_signed = div_op_signed(op_in);
   assign rs1_neg   = in_signed & rs1_i[XLEN-1];
   assign rs2_neg   = in_signed & rs2_i[XLEN-1];

   div_sign_fix #(.W(XLEN)) u_mag1 (.val(rs1_i),   .neg(rs1_neg), .res(mag1));
   div_sign_fix #(.W(XLEN)) u_mag2 (.val(rs2_i),   .neg(rs2_neg), .res(mag2));
   div_sign_fix #(.W(XLEN)) u_qfix (.val(div_q_i), .neg(q_neg),   .res(q_fix));
   div_sign_fix #(.W(XLEN)) u_rfix (.val(div_r_i), .neg(r_neg),   .res(r_fix));

`ifdef DIV_CTRL_RESULT_CACHE_EN
   logic            cache_vld;
   logic            cache_sgn;
   logic            complete;
   logic [XLEN-1:0] cache_rs1;
   logic [XLEN-1:0] cache_rs2;
   logic [XLEN-1:0] cache_q;
   logic [XLEN-1:0] cache_r;
   logic [XLEN-1:0] cur_rs1;
   logic [XLEN-1:0] cur_rs2;

   assign complete  = (state == DIV_ST_WAIT) && div_rdy_i && !flush_i;
   assign cache_hit = cache_vld && (rs1_i == cache_rs1) && (rs2_i == cache_rs2) &&
                      (in_signed == cache_sgn);
   assign hit_data  = div_op_rem(op_in) ? cache_r : cache_q;

   // raw operands of the request in flight, and the last completed core result
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_rs1   <= {XLEN{1'b0}};
         cur_rs2   <= {XLEN{1'b0}};
         cache_vld <= 1'b0;
         cache_sgn <= 1'b0;
         cache_rs1 <= {XLEN{1'b0}};
         cache_rs2 <= {XLEN{1'b0}};
         cache_q   <= {XLEN{1'b0}};
         cache_r   <= {XLEN{1'b0}};
      end else begin
         if (accept) begin
            cur_rs1 <= rs1_i;
            cur_rs2 <= rs2_i;
         end
         if (flush_i) begin
            cache_vld <= 1'b0;
         end else if (complete) begin
            cache_vld <= 1'b1;
            cache_sgn <= div_op_signed(op);
            cache_rs1 <= cur_rs1;
            cache_rs2 <= cur_rs2;
            cache_q   <= q_fix;
            cache_r   <= r_fix;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
   assign hit_data  = {XLEN{1'b0}};
`endif

   // next state and next response word
   always_comb begin
      state_nxt = state;
      rsp_nxt   = rsp_data_o;
      accept    = 1'b0;
      case (state)
         DIV_ST_IDLE: begin
            // a flush in the same cycle wins over a new request
            if (flush_i) begin
               state_nxt = DIV_ST_IDLE;
            end else if (req_vld_i && req_rdy_o) begin
               accept = 1'b1;
               if (rs2_i == {XLEN{1'b0}}) begin
                  state_nxt = DIV_ST_RESP;
                  rsp_nxt   = div_op_rem(op_in) ? rs1_i : DIV_BY_ZERO_Q;
               end else if (mag1 == {XLEN{1'b0}}) begin
                  state_nxt = DIV_ST_RESP;
                  rsp_nxt   = {XLEN{1'b0}};
               end else if (cache_hit) begin
                  state_nxt = DIV_ST_RESP;
                  rsp_nxt   = hit_data;
               end else begin
                  state_nxt = DIV_ST_START;
               end
            end else begin
               state_nxt = DIV_ST_IDLE;
            end
         end
         DIV_ST_START: begin
            // the start pulse is already out, so a flush must wait for the core
            if (flush_i) begin
               state_nxt = DIV_ST_DRAIN;
            end else begin
               state_nxt = DIV_ST_WAIT;
            end
         end
         DIV_ST_WAIT: begin
            if (div_rdy_i) begin
               if (flush_i) begin
                  state_nxt = DIV_ST_IDLE;
               end else begin
                  state_nxt = DIV_ST_RESP;
                  rsp_nxt   = div_op_rem(op) ? r_fix : q_fix;
               end
            end else if (flush_i) begin
               state_nxt = DIV_ST_DRAIN;
            end else begin
               state_nxt = DIV_ST_WAIT;
            end
         end
         DIV_ST_RESP: begin
            if (flush_i || rsp_rdy_i) begin
               state_nxt = DIV_ST_IDLE;
            end else begin
               state_nxt = DIV_ST_RESP;
            end
         end
         DIV_ST_DRAIN: begin
            if (div_rdy_i) begin
               state_nxt = DIV_ST_IDLE;
            end else begin
               state_nxt = DIV_ST_DRAIN;
            end
         end
         default: begin
            state_nxt = DIV_ST_IDLE;
         end
      endcase
   end

   // state, registered handshake outputs and latched operands
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DIV_ST_IDLE;
         req_rdy_o  <= 1'b1;
         rsp_vld_o  <= 1'b0;
         div_vld_o  <= 1'b0;
         rsp_data_o <= {XLEN{1'b0}};
         div_div1_o <= {XLEN{1'b0}};
         div_div2_o <= {XLEN{1'b0}};
         op         <= DIV_OP_DIV;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
      end else begin
         state      <= state_nxt;
         req_rdy_o  <= (state_nxt == DIV_ST_IDLE);
         rsp_vld_o  <= (state_nxt == DIV_ST_RESP);
         div_vld_o  <= (state_nxt == DIV_ST_START);
         rsp_data_o <= rsp_nxt;
         if (accept) begin
            op         <= op_in;
            q_neg      <= rs1_neg ^ rs2_neg;
            r_neg      <= rs1_neg;
            div_div1_o <= mag1;
            div_div2_o <= mag2;
         end
      end
   end

endmodule
